roimager_seq_gen2: RTL
======================

ROIMAGER_SEQ_GEN2 -- requirements
Module: roimager_seq_gen2

Interface
REQ-001 Parameter C_NUM_ROWS, default 160, mask rows streamed per load phase.
REQ-002 Parameter C_FIRST_TAIL, default 2, idle cycles after row stream in FIRST/LAST phases.
REQ-003 Parameter C_PAT_TAIL, default 268, idle cycles after row stream in pattern phase.
REQ-004 Parameter C_CNT_W, default 32, width of all config inputs and counters.
REQ-005 Port CLKMPRE  in  1  sole clock; every register updates on its rising edge.
REQ-006 Port RESET  in  1  synchronous, active-high reset.
REQ-007 Port START  in  1  leaves IDLE when high.
REQ-008 Port ABORT  in  1  synchronous return to IDLE.
REQ-009 Port MODE  in  1  0 = continuous frames, 1 = single frame.
REQ-010 Ports Exp_subc, Num_Pat, PROJ_DELAY, MIN_FRAME_TIME  in  C_CNT_W  exposure cycles, patterns per frame, trigger lead in cycles, minimum frame period in cycles.
REQ-011 Ports FSMIND0, FSMIND1ACK  in  1  handshake from downstream readout FSM.
REQ-012 Ports OK_PIXRES_GLOB, OK_DRAIN_B, STREAM, CLKMPRE_EN, TRIGGER_PROJ, FSMIND1, FSMIND0ACK, BUSY  out  1.
REQ-013 Ports CntSubc, FrameCnt  out  C_CNT_W  patterns done in current frame, frames completed.
REQ-014 Port fsm_stat  out  8  one-hot state code.

Function
REQ-015 States, one-hot fsm_stat: IDLE 0x01, FIRST 0x02, PAT 0x04, EXP 0x08, LAST 0x10, RDO 0x20, RDO_ACK 0x40; any other code -> IDLE next cycle.
REQ-016 IDLE: START=1 -> FIRST; Exp_subc, Num_Pat, PROJ_DELAY, MIN_FRAME_TIME latched on that edge; frame timer loaded with latched MIN_FRAME_TIME; CntSubc cleared.
REQ-017 Config changes after latching have no effect until next FIRST entry.
REQ-018 Load phase (FIRST, PAT, LAST): phase counter p from 0; STREAM=1 and CLKMPRE_EN=1 for p<C_NUM_ROWS; STREAM=0, CLKMPRE_EN=1 for tail cycles; exit when p=C_NUM_ROWS+tail-1.
REQ-019 FIRST (tail C_FIRST_TAIL): OK_PIXRES_GLOB=1, OK_DRAIN_B=0; exit -> PAT.
REQ-020 PAT (tail C_PAT_TAIL): exit -> EXP, CntSubc increments on exit edge.
REQ-021 TRIGGER_PROJ = one-cycle pulse in PAT at p = C_NUM_ROWS-PROJ_DELAY; PROJ_DELAY>=C_NUM_ROWS -> pulse at p=0; exactly one pulse per PAT.
REQ-022 EXP: OK_PIXRES_GLOB=0, OK_DRAIN_B=1, CLKMPRE_EN=0, STREAM=0; lasts max(Exp_subc,1) cycles; then CntSubc<max(Num_Pat,1) -> PAT, else -> LAST.
REQ-023 LAST (tail C_FIRST_TAIL): OK_DRAIN_B=0 on exit edge; exit -> RDO.
REQ-024 RDO: FSMIND1=1, FSMIND0ACK=0; FSMIND1ACK=1 -> RDO_ACK.
REQ-025 RDO_ACK: leave only when FSMIND0=1 and frame timer=0; on leaving FSMIND1=0, FSMIND0ACK=1 (held until next RDO), FrameCnt+1 (wraps at 2^C_CNT_W); MODE=0 -> FIRST (relatch, reload timer), MODE=1 -> IDLE.
REQ-026 Frame timer decrements each cycle outside IDLE, saturates at 0.
REQ-027 BUSY=1 in every state except IDLE.
REQ-028 ABORT=1 in any state -> IDLE next edge, outputs at reset values except FrameCnt, which is held; ABORT beats START in IDLE.
REQ-029 Counters p and exposure wrap never; phase lengths bounded by parameters and latched values.

Reset
REQ-030 RESET=1 at an edge: state IDLE, OK_PIXRES_GLOB=1, all other 1-bit outputs 0, CntSubc=0, FrameCnt=0, timers/counters 0; overrides ABORT and START; valid mid-frame.

Verification (C_NUM_ROWS=8, C_FIRST_TAIL=2, C_PAT_TAIL=4)
REQ-031 Reset then idle 10 cycles -> fsm_stat=0x01, OK_PIXRES_GLOB=1, all else 0.
REQ-032 MODE=1, Num_Pat=2, Exp_subc=3, PROJ_DELAY=3, MIN_FRAME_TIME=0, START pulse, FSMIND1ACK/FSMIND0 tied 1 -> FIRST 10 cycles, PAT 12, EXP 3, PAT 12, EXP 3, LAST 10; 2 TRIGGER_PROJ pulses each at PAT p=5; CntSubc=2; FrameCnt=1; return IDLE.
REQ-033 Same with MIN_FRAME_TIME=100 -> RDO_ACK held until cycle 100 after START edge.
REQ-034 MODE=0, Num_Pat=0, Exp_subc=0 -> one PAT, one 1-cycle EXP per frame; FrameCnt increments each loop; Num_Pat changed mid-frame takes effect next frame.
REQ-035 ABORT during EXP, then RESET during PAT of next frame -> IDLE next edge each time, OK_DRAIN_B=0, FrameCnt held then cleared.
REQ-036 PROJ_DELAY=20 -> trigger at PAT p=0.

Source files
------------

// File: rtl/roimager_seq_gen2.sv
// rtl/roimager_seq_gen2.sv - row-mask load / exposure / readout sequencer
// One-hot FSM; all outputs are registered from the next-state decode.
module roimager_seq_gen2 #(
  parameter int C_NUM_ROWS   = 160,
  parameter int C_FIRST_TAIL = 2,
  parameter int C_PAT_TAIL   = 268,
  parameter int C_CNT_W      = 32
) (
  input  logic               CLKMPRE,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic               MODE,
  input  logic [C_CNT_W-1:0] Exp_subc,
  input  logic [C_CNT_W-1:0] Num_Pat,
  input  logic [C_CNT_W-1:0] PROJ_DELAY,
  input  logic [C_CNT_W-1:0] MIN_FRAME_TIME,
  input  logic               FSMIND0,
  input  logic               FSMIND1ACK,
  output logic               OK_PIXRES_GLOB,
  output logic               OK_DRAIN_B,
  output logic               STREAM,
  output logic               CLKMPRE_EN,
  output logic               TRIGGER_PROJ,
  output logic               FSMIND1,
  output logic               FSMIND0ACK,
  output logic               BUSY,
  output logic [C_CNT_W-1:0] CntSubc,
  output logic [C_CNT_W-1:0] FrameCnt,
  output logic [7:0]         fsm_stat
);

  typedef enum logic [7:0] {
    S_IDLE    = 8'h01,
    S_FIRST   = 8'h02,
    S_PAT     = 8'h04,
    S_EXP     = 8'h08,
    S_LAST    = 8'h10,
    S_RDO     = 8'h20,
    S_RDO_ACK = 8'h40
  } state_t;

  localparam logic [C_CNT_W-1:0] ONE       = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] ROWS      = C_CNT_W'(C_NUM_ROWS);
  localparam logic [C_CNT_W-1:0] FIRST_END = C_CNT_W'(C_NUM_ROWS + C_FIRST_TAIL - 1);
  localparam logic [C_CNT_W-1:0] PAT_END   = C_CNT_W'(C_NUM_ROWS + C_PAT_TAIL - 1);

  state_t state, nxt_state;
  logic [C_CNT_W-1:0] cnt, nxt_cnt;
  logic [C_CNT_W-1:0] exp_l, npat_l, pdel_l, frame_tmr;
  logic [C_CNT_W-1:0] exp_len, npat_eff, trig_p;
  logic               nxt_load, first_entry, pat_exit, rdo_ack_exit;

  assign fsm_stat = state;
  assign exp_len  = (exp_l == '0) ? ONE : exp_l;
  assign npat_eff = (npat_l == '0) ? ONE : npat_l;
  assign trig_p   = (pdel_l >= ROWS) ? '0 : ROWS - pdel_l;

  assign nxt_load     = (nxt_state == S_FIRST) || (nxt_state == S_PAT) || (nxt_state == S_LAST);
  assign first_entry  = (nxt_state == S_FIRST) && (state != S_FIRST);
  assign pat_exit     = (state == S_PAT) && (nxt_state == S_EXP);
  assign rdo_ack_exit = (state == S_RDO_ACK) && (nxt_state != S_RDO_ACK);

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:    if (START) nxt_state = S_FIRST;
      S_FIRST:   if (cnt == FIRST_END) nxt_state = S_PAT;
      S_PAT:     if (cnt == PAT_END) nxt_state = S_EXP;
      S_EXP:     if (cnt >= exp_len - ONE) nxt_state = (CntSubc < npat_eff) ? S_PAT : S_LAST;
      S_LAST:    if (cnt == FIRST_END) nxt_state = S_RDO;
      S_RDO:     if (FSMIND1ACK) nxt_state = S_RDO_ACK;
      S_RDO_ACK: if (FSMIND0 && frame_tmr == '0) nxt_state = MODE ? S_IDLE : S_FIRST;
      default:   nxt_state = S_IDLE;
    endcase
    if (ABORT) nxt_state = S_IDLE;

    // One counter serves both the load phase position and the exposure length.
    nxt_cnt = '0;
    if (nxt_state == state && (nxt_load || state == S_EXP)) nxt_cnt = cnt + ONE;
  end

  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      state          <= S_IDLE;
      cnt            <= '0;
      exp_l          <= '0;
      npat_l         <= '0;
      pdel_l         <= '0;
      frame_tmr      <= '0;
      CntSubc        <= '0;
      FrameCnt       <= '0;
      OK_PIXRES_GLOB <= 1'b1;
      OK_DRAIN_B     <= 1'b0;
      STREAM         <= 1'b0;
      CLKMPRE_EN     <= 1'b0;
      TRIGGER_PROJ   <= 1'b0;
      FSMIND1        <= 1'b0;
      FSMIND0ACK     <= 1'b0;
      BUSY           <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (ABORT) begin
        frame_tmr  <= '0;
        CntSubc    <= '0;
        OK_DRAIN_B <= 1'b0;
        FSMIND0ACK <= 1'b0;
      end else begin
        if (first_entry) begin
          exp_l      <= Exp_subc;
          npat_l     <= Num_Pat;
          pdel_l     <= PROJ_DELAY;
          frame_tmr  <= MIN_FRAME_TIME;
          CntSubc    <= '0;
          OK_DRAIN_B <= 1'b0;
        end else if (state != S_IDLE && frame_tmr != '0) begin
          frame_tmr <= frame_tmr - ONE;
        end
        if (pat_exit) CntSubc <= CntSubc + ONE;
        if (nxt_state == S_EXP) OK_DRAIN_B <= 1'b1;
        if (state == S_LAST && nxt_state == S_RDO) OK_DRAIN_B <= 1'b0;
        if (nxt_state == S_RDO) FSMIND0ACK <= 1'b0;
        // FSMIND0ACK stays up after the frame until the next readout request.
        if (rdo_ack_exit) begin
          FSMIND0ACK <= 1'b1;
          FrameCnt   <= FrameCnt + ONE;
        end
      end
      OK_PIXRES_GLOB <= (nxt_state == S_IDLE) || (nxt_state == S_FIRST);
      CLKMPRE_EN     <= nxt_load;
      STREAM         <= nxt_load && (nxt_cnt < ROWS);
      TRIGGER_PROJ   <= (nxt_state == S_PAT) && (nxt_cnt == trig_p);
      FSMIND1        <= (nxt_state == S_RDO) || (nxt_state == S_RDO_ACK);
      BUSY           <= (nxt_state != S_IDLE);
    end
  end

endmodule
